line_fetch_scheduler: RTL

Sequences the display's per-line pixel fetch from the shared frame memory and arbitrates that memory port between scan-out and one writer (camera or drawing engine). Watches `hcount_in`/`vcount_in` from the video timing generator. At the start of each horizontal blank, it burst-reads the next display line into one half of a ping-pong line buffer. Outside those bursts it grants the port to the writer with a request/grant handshake.

---
 rtl/line_fetch_scheduler_if.sv | 26 ++
 rtl/line_fetch_scheduler.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/line_fetch_scheduler_if.sv
// Writer handshake and frame memory port shared by the line fetch scheduler.
// slave: scheduler side (grants writes, drives memory); master: writer/memory side.
interface line_fetch_scheduler_if #(
    parameter int ADDR_WIDTH = 18,
    parameter int DATA_WIDTH = 16
);
    logic                  wr_req_in;
    logic [ADDR_WIDTH-1:0] wr_addr_in;
    logic [DATA_WIDTH-1:0] wr_data_in;
    logic                  wr_gnt_out;
    logic                  mem_en_out;
    logic                  mem_we_out;
    logic [ADDR_WIDTH-1:0] mem_addr_out;
    logic [DATA_WIDTH-1:0] mem_wdata_out;
    logic [DATA_WIDTH-1:0] mem_rdata_in;

    modport slave (
        input  wr_req_in, wr_addr_in, wr_data_in, mem_rdata_in,
        output wr_gnt_out, mem_en_out, mem_we_out, mem_addr_out, mem_wdata_out
    );

    modport master (
        output wr_req_in, wr_addr_in, wr_data_in, mem_rdata_in,
        input  wr_gnt_out, mem_en_out, mem_we_out, mem_addr_out, mem_wdata_out
    );
endinterface

// File: rtl/line_fetch_scheduler.sv
// Per-line burst fetch into a ping-pong line buffer; writer gets the port otherwise.
// Ports: clk/rst, h/v counters, bus (writer + memory), line buffer write, status.
module line_fetch_scheduler #(
    parameter int ACTIVE_H_PIXELS = 1280,
    parameter int TOTAL_PIXELS    = 1650,
    parameter int ACTIVE_LINES    = 720,
    parameter int TOTAL_LINES     = 750,
    parameter int LINE_WORDS      = 320,
    parameter int ADDR_WIDTH      = 18,
    parameter int DATA_WIDTH      = 16,
    parameter int RD_LATENCY      = 2
) (
    input  logic                            clk_pixel_in,
    input  logic                            rst_in,
    input  logic [$clog2(TOTAL_PIXELS)-1:0] hcount_in,
    input  logic [$clog2(TOTAL_LINES)-1:0]  vcount_in,
    line_fetch_scheduler_if.slave           bus,
    output logic                            lb_we_out,
    output logic [$clog2(LINE_WORDS)-1:0]   lb_addr_out,
    output logic [DATA_WIDTH-1:0]           lb_data_out,
    output logic                            lb_bank_out,
    output logic                            line_ready_out,
    output logic                            underrun_out
);
    localparam int HW = $clog2(TOTAL_PIXELS);
    localparam int VW = $clog2(TOTAL_LINES);
    localparam int IW = $clog2(LINE_WORDS);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

    state_e                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  bank_q, bank_d;
    logic                  mem_en_q, mem_en_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  ready_q, ready_d;
    logic                  und_q, und_d;
    logic                  lb_we_q;
    logic [IW-1:0]         lb_addr_q;
    logic [DATA_WIDTH-1:0] lb_data_q;
    logic [RD_LATENCY-1:0] pv_q;
    logic [IW-1:0]         pi_q [RD_LATENCY];

    logic                  last_line;
    logic                  trig;
    logic [VW-1:0]         tgt;
    logic [ADDR_WIDTH-1:0] base;
    logic                  gnt;

    assign last_line = (vcount_in == VW'(TOTAL_LINES - 1));
    assign trig = (hcount_in == HW'(ACTIVE_H_PIXELS)) &&
                  ((vcount_in < VW'(ACTIVE_LINES - 1)) || last_line);
    assign tgt  = last_line ? '0 : vcount_in + 1'b1;
    // Direct product rather than an accumulator so a fetch after reset or a
    // discarded trigger still lands on the right line.
    assign base = ADDR_WIDTH'(32'(tgt) * 32'(LINE_WORDS));

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        bank_d      = bank_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        ready_d     = 1'b0;
        und_d       = und_q;
        gnt         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (trig) begin
                    state_d    = FETCH;
                    idx_d      = '0;
                    bank_d     = tgt[0];
                    mem_en_d   = 1'b1;
                    mem_addr_d = base;
                end else if (bus.wr_req_in) begin
                    gnt         = 1'b1;
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = bus.wr_addr_in;
                    mem_wdata_d = bus.wr_data_in;
                end
            end
            FETCH: begin
                if (idx_q == IW'(LINE_WORDS - 1)) begin
                    state_d = DRAIN;
                end else begin
                    idx_d      = idx_q + 1'b1;
                    mem_en_d   = 1'b1;
                    mem_addr_d = mem_addr_q + 1'b1;
                end
            end
            DRAIN: begin
                // Last buffer write is visible now; pulse and free the port.
                if (lb_we_q && (lb_addr_q == IW'(LINE_WORDS - 1))) begin
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (trig && (state_q != IDLE)) begin
            und_d = 1'b1;
        end
    end

    always_ff @(posedge clk_pixel_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            bank_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ready_q     <= 1'b0;
            und_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            bank_q      <= bank_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ready_q     <= ready_d;
            und_q       <= und_d;
        end
    end

    // Valid/index travel alongside the memory read latency.
    always_ff @(posedge clk_pixel_in or negedge rst_in) begin
        if (!rst_in) begin
            pv_q      <= '0;
            for (int k = 0; k < RD_LATENCY; k++) begin
                pi_q[k] <= '0;
            end
            lb_we_q   <= 1'b0;
            lb_addr_q <= '0;
            lb_data_q <= '0;
        end else begin
            pv_q[0] <= (state_q == FETCH);
            pi_q[0] <= idx_q;
            for (int k = 1; k < RD_LATENCY; k++) begin
                pv_q[k] <= pv_q[k-1];
                pi_q[k] <= pi_q[k-1];
            end
            lb_we_q <= pv_q[RD_LATENCY-1];
            if (pv_q[RD_LATENCY-1]) begin
                lb_addr_q <= pi_q[RD_LATENCY-1];
                lb_data_q <= bus.mem_rdata_in;
            end
        end
    end

    assign bus.wr_gnt_out    = gnt && rst_in;
    assign bus.mem_en_out    = mem_en_q;
    assign bus.mem_we_out    = mem_we_q;
    assign bus.mem_addr_out  = mem_addr_q;
    assign bus.mem_wdata_out = mem_wdata_q;
    assign lb_we_out         = lb_we_q;
    assign lb_addr_out       = lb_addr_q;
    assign lb_data_out       = lb_data_q;
    assign lb_bank_out       = bank_q;
    assign line_ready_out    = ready_q;
    assign underrun_out      = und_q;
endmodule
